seq_divider: RTL

//   Multi-cycle unsigned restoring divider. It is the inverse-direction arithmetic companion
//   to the combinational adder datapath: one trial subtraction per clock, one quotient bit
//   per clock, WIDTH iterations per operation.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_sub_stage.sv | 18 +
 rtl/seq_divider.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e    : FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   DBZ_Q_FILL : fill bit for the unsigned divide-by-zero quotient (all ones)
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/seq_divider_sub_stage.sv
// One trial subtraction of the restoring divider.
//   rem_i     [WIDTH:0]   shifted partial remainder
//   divisor_i [WIDTH-1:0] divisor
//   diff_o    [WIDTH:0]   rem_i - divisor_i
//   borrow_o              1 when divisor_i > rem_i (trial must be discarded)
module div_sub_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   diff_o,
  output logic             borrow_o
);

  // One extra MSB on both operands turns the wrap-around into the borrow flag.
  assign {borrow_o, diff_o} = {1'b0, rem_i} - {2'b00, divisor_i};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      operand handshake; dividend, divisor [WIDTH-1:0]
//   out_valid / out_ready    result handshake; quotient, remainder [WIDTH-1:0], div_by_zero
// Build option: SEQ_DIVIDER_SIGNED_EN selects two's-complement operands (magnitudes are
// divided, signs restored on the last iteration). Undefined: unsigned only.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | iterating, one trial subtraction per edge, cnt counts down from WIDTH
// DONE  | result presented, out_valid=1, held until out_ready
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_diff;
  logic             sub_borrow;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction
`endif

  // {rem,quo} shifted left by one: the quotient MSB moves into the remainder LSB.
  assign shifted = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .rem_i     (shifted),
    .divisor_i (dvs_q),
    .diff_o    (sub_diff),
    .borrow_o  (sub_borrow)
  );

  assign step_rem = sub_borrow ? shifted : sub_diff;
  assign step_quo = {quo_q[WIDTH-2:0], ~sub_borrow};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dbz_d = (divisor == '0);
          cnt_d = CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
          qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d = dividend[WIDTH-1];
          dvs_d  = mag(divisor);
          if (divisor == '0) begin
            quo_d = dividend[WIDTH-1] ? WIDTH'(1) : {WIDTH{DBZ_Q_FILL}};
            rem_d = {1'b0, dividend};
          end else begin
            quo_d = mag(dividend);
            rem_d = '0;
          end
`else
          dvs_d = divisor;
          if (divisor == '0) begin
            quo_d = {WIDTH{DBZ_Q_FILL}};
            rem_d = {1'b0, dividend};
          end else begin
            quo_d = dividend;
            rem_d = '0;
          end
`endif
          state_d = (divisor == '0) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
          // Sign fix-up folded into the final iteration so latency matches unsigned.
          if (qneg_q) quo_d = ~step_quo + 1'b1;
          if (rneg_q) rem_d = {1'b0, ~step_rem[WIDTH-1:0] + 1'b1};
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule
